// File: rtl/l1_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : l1_cache_pkg                                           |
// | Description : Shared types and widths for the direct-mapped L1 cache |
// |               (state encoding, line type, byte-mask helper).         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package l1_cache_pkg;

    localparam int c_ADDR_W   = 32;
    localparam int c_WORD_W   = 32;
    localparam int c_LINE_W   = 256;
    localparam int c_LINE_B   = 32;   // bytes per line
    localparam int c_OFFSET_W = 5;
    localparam int c_INDEX_W  = 3;
    localparam int c_TAG_W    = c_ADDR_W - c_INDEX_W - c_OFFSET_W;

    typedef logic [c_LINE_W-1:0] cache_line_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_state_t;

    // Expands a word-level byte enable into the line-level byte write mask.
    function automatic logic [c_LINE_B-1:0] word_byte_mask(input logic [2:0] word,
                                                          input logic [3:0] be);
        logic [c_LINE_B-1:0] m;
        m = '0;
        m[{word, 2'b00} +: 4] = be;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_cache_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : l1_cache_if                                            |
// | Description : CPU word channel plus memory line channel of one L1    |
// |               cache. slave = cache view, master = CPU/pmem view.     |
// |   mem_*  : addr/read/write/byte_enable/wdata in, rdata/resp out      |
// |   pmem_* : address/read/write/wdata out, rdata/resp in               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface l1_cache_if;
    import l1_cache_pkg::*;

    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    logic [31:0] pmem_address;
    cache_line_t pmem_rdata;
    cache_line_t pmem_wdata;
    logic        pmem_read;
    logic        pmem_write;
    logic        pmem_resp;

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_wdata, pmem_read, pmem_write,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_addr, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_wdata, pmem_read, pmem_write,
        output pmem_rdata, pmem_resp
    );

endinterface
`default_nettype wire

// File: rtl/l1_cache_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cache_array                                            |
// | Description : Flop-based array, one entry per cache line. Combina-   |
// |               tional read, masked write on the rising edge, optional |
// |               asynchronous clear (used for valid/dirty bits).        |
// |   i_we/i_waddr/i_wdata/i_wmask : write port (mask lane=WIDTH/MASK_W) |
// |   i_raddr/o_rdata              : read port                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cache_array #(
    parameter int S_INDEX     = 3,
    parameter int WIDTH       = 1,
    parameter int MASK_W      = 1,
    parameter int ASYNC_CLEAR = 0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_we,
    input  wire logic [S_INDEX-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]   i_wdata,
    input  wire logic [MASK_W-1:0]  i_wmask,
    input  wire logic [S_INDEX-1:0] i_raddr,
    output logic      [WIDTH-1:0]   o_rdata
);

    localparam int c_DEPTH  = 2 ** S_INDEX;
    localparam int c_LANE_W = WIDTH / MASK_W;

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [WIDTH-1:0] w_merged;

    assign o_rdata = r_mem[i_raddr];

    // Lanes with a clear mask bit keep their stored contents.
    always_comb begin
        w_merged = r_mem[i_waddr];
        for (int l = 0; l < MASK_W; l++) begin
            if (i_wmask[l]) begin
                w_merged[l*c_LANE_W +: c_LANE_W] = i_wdata[l*c_LANE_W +: c_LANE_W];
            end
        end
    end

    generate
        if (ASYNC_CLEAR != 0) begin : g_async_clear
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c_DEPTH; i++) begin
                        r_mem[i] <= '0;
                    end
                end else if (i_we) begin
                    r_mem[i_waddr] <= w_merged;
                end
            end
        end else begin : g_no_clear
            logic w_unused_rst;
            assign w_unused_rst = rst_n;
            always_ff @(posedge clk) begin
                if (i_we) begin
                    r_mem[i_waddr] <= w_merged;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/l1_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : l1_cache                                               |
// | Description : Direct-mapped, write-back, write-allocate L1 cache.    |
// |               Zero-wait-state hits; misses write back a dirty victim |
// |               then fill the line from memory before responding.      |
// |   clk, rst_n (async, active-low)                                     |
// |   bus (l1_cache_if.slave) : CPU word channel + 256-bit line channel  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module l1_cache
    import l1_cache_pkg::*;
#(
    parameter int S_INDEX  = 3,
    parameter int S_OFFSET = 5   // only 5 (256-bit lines) is supported
) (
    input  wire logic clk,
    input  wire logic rst_n,
    l1_cache_if.slave bus
);

    localparam int c_TAG_BITS = 32 - S_INDEX - S_OFFSET;

    cache_state_t r_state;
    cache_state_t w_next_state;
    logic [31:0]  r_miss_addr;

    logic [31:0]           w_addr_sel;
    logic [c_TAG_BITS-1:0] w_req_tag;
    logic [S_INDEX-1:0]    w_index;
    logic [2:0]            w_word;
    logic                  w_req;
    logic                  w_hit;

    cache_line_t           w_line_rd;
    logic [c_TAG_BITS-1:0] w_tag_rd;
    logic                  w_valid_rd;
    logic                  w_dirty_rd;

    logic                  w_resp;
    logic                  w_pmem_read;
    logic                  w_pmem_write;
    logic [31:0]           w_pmem_addr;
    logic                  w_miss_latch;
    logic                  w_data_we;
    cache_line_t           w_data_wdata;
    logic [c_LINE_B-1:0]   w_data_mask;
    logic                  w_tag_we;
    logic                  w_valid_we;
    logic                  w_dirty_we;
    logic                  w_dirty_wdata;
    logic                  w_unused_bits;

    // Once a miss is accepted the line being serviced comes from the latched
    // address, so a CPU that drops or changes its request cannot disturb it.
    assign w_addr_sel = (r_state == IDLE) ? bus.mem_addr : r_miss_addr;
    assign w_req_tag  = w_addr_sel[31 -: c_TAG_BITS];
    assign w_index    = w_addr_sel[S_OFFSET +: S_INDEX];
    assign w_word     = bus.mem_addr[4:2];
    assign w_req      = bus.mem_read | bus.mem_write;
    assign w_hit      = w_valid_rd && (w_tag_rd == w_req_tag);

    assign w_unused_bits = ^{w_addr_sel[S_OFFSET-1:0], bus.mem_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_miss_latch) begin
                r_miss_addr <= bus.mem_addr;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_resp        = 1'b0;
        w_pmem_read   = 1'b0;
        w_pmem_write  = 1'b0;
        w_pmem_addr   = '0;
        w_miss_latch  = 1'b0;
        w_data_we     = 1'b0;
        w_data_wdata  = {8{bus.mem_wdata}};
        w_data_mask   = word_byte_mask(w_word, bus.mem_byte_enable);
        w_tag_we      = 1'b0;
        w_valid_we    = 1'b0;
        w_dirty_we    = 1'b0;
        w_dirty_wdata = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        w_resp = 1'b1;
                        // Write wins when read and write are both raised.
                        if (bus.mem_write) begin
                            w_data_we = 1'b1;
                            if (bus.mem_byte_enable != 4'b0000) begin
                                w_dirty_we    = 1'b1;
                                w_dirty_wdata = 1'b1;
                            end
                        end
                    end else begin
                        w_miss_latch = 1'b1;
                        w_next_state = (w_valid_rd && w_dirty_rd) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                w_pmem_write = 1'b1;
                w_pmem_addr  = {w_tag_rd, w_index, {S_OFFSET{1'b0}}};
                if (bus.pmem_resp) begin
                    w_dirty_we   = 1'b1;
                    w_next_state = FILL;
                end
            end
            FILL: begin
                w_pmem_read = 1'b1;
                w_pmem_addr = {w_req_tag, w_index, {S_OFFSET{1'b0}}};
                if (bus.pmem_resp) begin
                    w_data_we    = 1'b1;
                    w_data_wdata = bus.pmem_rdata;
                    w_data_mask  = '1;
                    w_tag_we     = 1'b1;
                    w_valid_we   = 1'b1;
                    w_dirty_we   = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign bus.mem_resp     = w_resp;
    assign bus.mem_rdata    = (w_resp && !bus.mem_write) ? w_line_rd[{w_word, 5'b00000} +: 32] : 32'h0;
    assign bus.pmem_read    = w_pmem_read;
    assign bus.pmem_write   = w_pmem_write;
    assign bus.pmem_address = w_pmem_addr;
    assign bus.pmem_wdata   = w_line_rd;   // index is latched, so victim data is stable

    cache_array #(.S_INDEX(S_INDEX), .WIDTH(c_LINE_W), .MASK_W(c_LINE_B), .ASYNC_CLEAR(0)) u_data (
        .clk(clk), .rst_n(rst_n), .i_we(w_data_we), .i_waddr(w_index),
        .i_wdata(w_data_wdata), .i_wmask(w_data_mask), .i_raddr(w_index), .o_rdata(w_line_rd)
    );

    cache_array #(.S_INDEX(S_INDEX), .WIDTH(c_TAG_BITS), .MASK_W(1), .ASYNC_CLEAR(0)) u_tag (
        .clk(clk), .rst_n(rst_n), .i_we(w_tag_we), .i_waddr(w_index),
        .i_wdata(w_req_tag), .i_wmask(1'b1), .i_raddr(w_index), .o_rdata(w_tag_rd)
    );

    cache_array #(.S_INDEX(S_INDEX), .WIDTH(1), .MASK_W(1), .ASYNC_CLEAR(1)) u_valid (
        .clk(clk), .rst_n(rst_n), .i_we(w_valid_we), .i_waddr(w_index),
        .i_wdata(1'b1), .i_wmask(1'b1), .i_raddr(w_index), .o_rdata(w_valid_rd)
    );

    cache_array #(.S_INDEX(S_INDEX), .WIDTH(1), .MASK_W(1), .ASYNC_CLEAR(1)) u_dirty (
        .clk(clk), .rst_n(rst_n), .i_we(w_dirty_we), .i_waddr(w_index),
        .i_wdata(w_dirty_wdata), .i_wmask(1'b1), .i_raddr(w_index), .o_rdata(w_dirty_rd)
    );

    a_no_read_and_write: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.mem_read && bus.mem_write));

endmodule
`default_nettype wire

// File: tb/tb_l1_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_l1_cache                                            |
// | Description : Self-checking bench for l1_cache: directed scenarios   |
// |               followed by random accesses, compared against a flat   |
// |               memory view plus a per-index residency model.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_l1_cache;
    import l1_cache_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l1_cache_if bus();

    l1_cache #(.S_INDEX(3), .S_OFFSET(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int checks = 0;
    int failures = 0;

    // Backing memory (line granular) and CPU-visible memory (word granular).
    bit [255:0] pmem_store [int unsigned];
    bit [31:0]  flat [int unsigned];
    int pmem_delay = 5;

    logic [31:0]  wb_addr_q[$];
    logic [255:0] wb_data_q[$];
    logic [31:0]  rd_addr_q[$];
    logic [31:0]  last_rdata;
    logic [31:0]  last_wb_addr;
    logic [255:0] last_wb_data;

    int both_high = 0;
    int resp_with_pmem = 0;
    int misaligned = 0;

    // Residency model: which tag each index holds and whether it is dirty.
    bit        m_valid [8];
    bit [23:0] m_tag   [8];
    bit        m_dirty [8];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] init_word(input bit [31:0] waddr);
        return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit [255:0] pmem_line(input bit [31:0] la);
        bit [255:0] l;
        if (pmem_store.exists(la)) return pmem_store[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(4*w));
        return l;
    endfunction

    function automatic bit [31:0] cpu_word(input bit [31:0] addr);
        bit [31:0]  wa;
        bit [255:0] l;
        int         w;
        wa = {addr[31:2], 2'b00};
        if (flat.exists(wa)) return flat[wa];
        l = pmem_line({addr[31:5], 5'b0});
        w = int'(addr[4:2]);
        return l[w*32 +: 32];
    endfunction

    function automatic bit [255:0] cpu_line(input bit [31:0] la);
        bit [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = cpu_word(la + 32'(4*w));
        return l;
    endfunction

    task automatic preload_word(input bit [31:0] addr, input bit [31:0] val);
        bit [255:0] l;
        bit [31:0]  la;
        int         w;
        la = {addr[31:5], 5'b0};
        l = pmem_line(la);
        w = int'(addr[4:2]);
        l[w*32 +: 32] = val;
        pmem_store[la] = l;
        flat[{addr[31:2], 2'b00}] = val;
    endtask

    // Memory responder: answers a held pmem request after pmem_delay cycles.
    initial begin : pmem_responder
        int cnt;
        cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                cnt = 0;
            end else if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
                cnt++;
                if (cnt >= pmem_delay) begin
                    if (bus.pmem_write) begin
                        pmem_store[bus.pmem_address] = bus.pmem_wdata;
                        wb_addr_q.push_back(bus.pmem_address);
                        wb_data_q.push_back(bus.pmem_wdata);
                    end else begin
                        bus.pmem_rdata = pmem_line(bus.pmem_address);
                        rd_addr_q.push_back(bus.pmem_address);
                    end
                    bus.pmem_resp = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Protocol monitor.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus.pmem_read && bus.pmem_write) both_high++;
                if (bus.mem_resp && (bus.pmem_read || bus.pmem_write)) resp_with_pmem++;
                if ((bus.pmem_read || bus.pmem_write) && (bus.pmem_address[4:0] != 5'd0)) misaligned++;
            end
        end
    end

    task automatic cpu_op(input logic [31:0] addr, input bit wr, input logic [3:0] be, input logic [31:0] wd);
        logic [2:0]   idx;
        bit [23:0]    tg;
        bit           exp_hit, exp_wb, done;
        logic [31:0]  victim, exp_rd, wa, nw;
        logic [255:0] victim_line;
        int           exp_cyc, cyc;
        idx = addr[7:5];
        tg  = addr[31:8];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
        victim  = {m_tag[idx], idx, 5'b0};
        victim_line = cpu_line(victim);
        exp_rd  = cpu_word(addr);
        exp_cyc = exp_hit ? 0 : (exp_wb ? 2*pmem_delay + 2 : pmem_delay + 1);
        wb_addr_q.delete();
        wb_data_q.delete();
        rd_addr_q.delete();

        @(negedge clk);
        bus.mem_addr = addr;
        bus.mem_read = !wr;
        bus.mem_write = wr;
        bus.mem_byte_enable = be;
        bus.mem_wdata = wd;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            #1;
            if (bus.mem_resp) done = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        last_rdata = bus.mem_rdata;
        check("resp_seen", 256'(done), 256'(1));
        if (done) begin
            check("latency", 256'(cyc), 256'(exp_cyc));
            if (!wr) check("rdata", 256'(last_rdata), 256'(exp_rd));
            check("wb_count", 256'(wb_addr_q.size()), 256'(exp_wb));
            if (exp_wb && wb_addr_q.size() > 0) begin
                check("wb_addr", 256'(wb_addr_q[0]), 256'(victim));
                check("wb_data", wb_data_q[0], victim_line);
            end
            check("fill_count", 256'(rd_addr_q.size()), 256'(!exp_hit));
            if (!exp_hit && rd_addr_q.size() > 0)
                check("fill_addr", 256'(rd_addr_q[0]), 256'({addr[31:5], 5'b0}));
        end
        last_wb_addr = (wb_addr_q.size() > 0) ? wb_addr_q[0] : 32'h0;
        last_wb_data = (wb_data_q.size() > 0) ? wb_data_q[0] : 256'h0;
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;

        if (!exp_hit) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            wa = {addr[31:2], 2'b00};
            nw = cpu_word(addr);
            for (int b = 0; b < 4; b++) if (be[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
            flat[wa] = nw;
            if (be != 4'b0000) m_dirty[idx] = 1'b1;
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int cyc;
        logic [31:0] a;
        bus.mem_addr = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i] = '0;
            m_dirty[i] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_resp", 256'(bus.mem_resp), 256'(0));
        check("rst_pmem_read", 256'(bus.pmem_read), 256'(0));
        check("rst_pmem_write", 256'(bus.pmem_write), 256'(0));
        check("rst_mem_rdata", 256'(bus.mem_rdata), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: cold read with 5-cycle fill
        preload_word(32'h40, 32'hDEAD_BEEF);
        preload_word(32'h44, 32'hAAAA_AAAA);
        pmem_delay = 5;
        cpu_op(32'h40, 1'b0, 4'h0, 32'h0);
        check("t1_rdata", 256'(last_rdata), 256'(32'hDEAD_BEEF));

        // 2: partial write hit, then read back merged word
        cpu_op(32'h44, 1'b1, 4'b0011, 32'h1234_5678);
        cpu_op(32'h44, 1'b0, 4'h0, 32'h0);
        check("t2_merged", 256'(last_rdata), 256'(32'hAAAA_5678));

        // 3: conflict read forces writeback of the dirty line
        cpu_op(32'h144, 1'b0, 4'h0, 32'h0);
        check("t3_wb_addr", 256'(last_wb_addr), 256'(32'h40));
        check("t3_wb_word1", 256'(last_wb_data[63:32]), 256'(32'hAAAA_5678));

        // 4: reset while a fill is outstanding
        pmem_delay = 50;
        @(negedge clk);
        bus.mem_addr = 32'h40;
        bus.mem_read = 1'b1;
        cyc = 0;
        while (!bus.pmem_read && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("t4_fill_active", 256'(bus.pmem_read), 256'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_rst_pmem_read", 256'(bus.pmem_read), 256'(0));
        check("t4_rst_pmem_write", 256'(bus.pmem_write), 256'(0));
        check("t4_rst_mem_resp", 256'(bus.mem_resp), 256'(0));
        bus.mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        flat.delete();
        pmem_delay = 3;
        cpu_op(32'h40, 1'b0, 4'h0, 32'h0);

        // 5: three back-to-back hits
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            a = 32'h40 + 32'(4*i);
            bus.mem_addr = a;
            bus.mem_read = 1'b1;
            #1;
            check("t5_resp", 256'(bus.mem_resp), 256'(1));
            check("t5_rdata", 256'(bus.mem_rdata), 256'(cpu_word(a)));
            check("t5_pmem_idle", 256'(bus.pmem_read | bus.pmem_write), 256'(0));
        end
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;

        // 6: be=0 write hit leaves line clean, conflict miss skips writeback
        cpu_op(32'h48, 1'b1, 4'b0000, 32'hFFFF_FFFF);
        cpu_op(32'h148, 1'b0, 4'h0, 32'h0);
        check("t6_no_wb", 256'(wb_addr_q.size()), 256'(0));

        // Random traffic over four tags per index
        for (int n = 0; n < 80; n++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            pmem_delay = int'($urandom_range(1, 4));
            cpu_op(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        end

        check("never_both_high", 256'(both_high), 256'(0));
        check("no_resp_outside_idle", 256'(resp_with_pmem), 256'(0));
        check("pmem_addr_aligned", 256'(misaligned), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
